aim_param: RTL
==============

Name: aim_param

Overview:
- Parametrised associative index matcher for the object-tracking datapath.
- Compares N_WORD query words against an N_ENTRY index table and reports, per word, whether a match exists and the lowest matching table position.
- The table is scanned LANES entries per cycle under a start/finish handshake; the scan can stop early once every word has matched.
- Successor of the fixed 32-word/256-entry matcher. Adds generic sizing, key-slice selection by iteration, a busy flag and a defined no-match encoding.

Parameters:
- N_WORD, 32, number of query words
- WORD_W, 16, query word width
- N_ENTRY, 256, index table depth; must be a multiple of LANES
- KEY_W, 6, table entry and key width; KEY_W <= WORD_W
- LANES, 16, table entries compared per cycle
- ITE_W, 3, iteration selector width
- POS_W, $clog2(N_ENTRY)+1, position width; the extra bit allows the no-match code

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, synchronous active-high reset
- i_start, in, 1, start pulse, sampled only in IDLE
- i_ite, in, ITE_W, key-slice selector, latched at start
- i_word, in, N_WORD x WORD_W, query words, latched at start
- i_IA, in, N_ENTRY x KEY_W, index table, not latched; must be held stable while o_busy=1
- o_busy, out, 1, high from the cycle after start through the DONE cycle
- o_finish, out, 1, one-cycle completion pulse
- o_valid, out, N_WORD x 1, per-word match found
- o_pos, out, N_WORD x POS_W, lowest matching index; all-ones when there is no match

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE, block counter=0.
  - o_busy=0, o_finish=0, all o_valid=0, all o_pos=all-ones (511 at defaults).
  - Reset wins over any other event in the same cycle, including in mid-search.
- Key formation at start:
  - shift = min(i_ite, WORD_W-KEY_W).
  - key[w] = i_word[w][shift +: KEY_W].
  - Keys are stored in registers.
- FSM, IDLE -> SEARCH -> DONE -> IDLE:
  - IDLE:
    - On i_start=1: latch the keys, clear o_valid, set o_pos to all-ones, set blk=0, go to SEARCH.
    - Otherwise hold all outputs.
  - SEARCH, each cycle:
    - Compare every key against entries blk*LANES .. blk*LANES+LANES-1.
    - For each word with o_valid=0 and at least one hit: set o_valid=1 and o_pos = blk*LANES + lowest hit lane.
    - A word already valid is never updated, so the lowest position wins across blocks.
    - Leave to DONE after the last block (blk = N_ENTRY/LANES-1), or per the early-exit rule (Optional Feature).
    - Otherwise blk = blk+1.
  - DONE: o_finish=1 for exactly this one cycle, then go to IDLE.
- i_start while SEARCH or DONE: ignored; no restart and no queuing.
- Latency, with start sampled at edge t and B = N_ENTRY/LANES:
  - Full scan: SEARCH evaluations at edges t+1 .. t+B; o_finish is high in the cycle after edge t+B (B=16 at defaults).
  - Early exit: if all words are valid after the evaluation at edge t+1+k, o_finish is high in the cycle after that edge.
- o_valid/o_pos hold their values after finish until the next accepted start or a reset.
- Elaboration check: error if N_ENTRY % LANES != 0 or KEY_W > WORD_W.

Optional Feature:
- Macro: AIM_EARLY_EXIT_EN.
- Defined: SEARCH goes to DONE as soon as all N_WORD o_valid bits (including those set this cycle) are 1.
- Undefined: the full B-block scan always runs, giving fixed latency.
- Results are identical either way; only the timing of o_finish and o_busy differs.

Decomposition:
- Package aim_pkg: FSM state enum (IDLE, SEARCH, DONE), aim_pos_w() helper, NO_MATCH all-ones constant function.
- Sub-module aim_lane_cmp: combinational. Inputs: one key and LANES entries. Outputs: hit and lowest hit lane index (priority encoder). Instantiated N_WORD times.

Test Plan:
- Identity match: i_word[i]=i and IA[i]=i for i<32, IA[32..255]=63, ite=0 -> o_valid all 1, o_pos[i]=i. With AIM_EARLY_EXIT_EN: finish after 2 search cycles. Without it: after 16.
- Duplicate entries: IA[5]=IA[200]=7, word0=7, ite=0 -> o_valid[0]=1, o_pos[0]=5 (the later block hit is ignored).
- No match: word0=0x003F, no entry equals 63 -> o_valid[0]=0, o_pos[0]=511, o_finish 16 cycles after start.
- Iteration slice: ite=3, word0=0x0140 gives key 40; IA[100]=40, no other 40 -> o_pos[0]=100, o_valid[0]=1.
- Handshake: i_start pulsed again mid-SEARCH -> ignored, single o_finish pulse, results unchanged; o_busy=1 for the whole search.
- Reset mid-search (i_rst at search cycle 3) -> next cycle IDLE, o_busy=0, o_valid all 0, o_pos all 511, no o_finish.

Source files
------------

// File: rtl/aim_pkg.sv
// aim_pkg: shared FSM state type and sizing helpers for the associative index matcher
package aim_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} aim_state_e;
  function automatic int aim_pos_w(input int n_entry);
    return $clog2(n_entry) + 1;
  endfunction
  function automatic logic [31:0] no_match(input int pos_w);
    return (32'd1 << pos_w) - 32'd1;
  endfunction
endpackage

// File: rtl/aim_lane_cmp.sv
// aim_lane_cmp: compares one key against LANES table entries, reports hit and lowest hit lane
module aim_lane_cmp #(
  parameter int KEY_W = 6,
  parameter int LANES = 16,
  parameter int LANE_W = LANES > 1 ? $clog2(LANES) : 1
) (
  input  logic [KEY_W-1:0]            key,
  input  logic [LANES-1:0][KEY_W-1:0] entries,
  output logic                        hit,
  output logic [LANE_W-1:0]           lane
);
  always_comb begin
    hit = 1'b0;
    lane = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (entries[l] == key) begin
        hit = 1'b1;
        lane = LANE_W'(l);
      end
    end
  end
endmodule

// File: rtl/aim_param.sv
// aim_param: parametrised associative index matcher; AIM_EARLY_EXIT_EN stops the scan once every word has matched
module aim_param import aim_pkg::*; #(
  parameter int N_WORD = 32,
  parameter int WORD_W = 16,
  parameter int N_ENTRY = 256,
  parameter int KEY_W = 6,
  parameter int LANES = 16,
  parameter int ITE_W = 3,
  parameter int POS_W = aim_pos_w(N_ENTRY)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [ITE_W-1:0]                  i_ite,
  input  logic [N_WORD-1:0][WORD_W-1:0]     i_word,
  input  logic [N_ENTRY-1:0][KEY_W-1:0]     i_IA,
  output logic                              o_busy,
  output logic                              o_finish,
  output logic [N_WORD-1:0]                 o_valid,
  output logic [N_WORD-1:0][POS_W-1:0]      o_pos
);
  localparam int N_BLK = N_ENTRY / LANES;
  localparam int BLK_W = N_BLK > 1 ? $clog2(N_BLK) : 1;
  localparam int LANE_W = LANES > 1 ? $clog2(LANES) : 1;
  localparam int IDX_W = N_ENTRY > 1 ? $clog2(N_ENTRY) : 1;
  localparam int SH_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam int MAX_SHIFT = WORD_W - KEY_W;
  localparam logic [POS_W-1:0] NO_POS = POS_W'(no_match(POS_W));
  if (N_ENTRY % LANES != 0 || KEY_W > WORD_W) begin : g_bad_cfg
    $error("aim_param: N_ENTRY must be a multiple of LANES and KEY_W must not exceed WORD_W");
  end
  aim_state_e state;
  logic [BLK_W-1:0] blk;
  logic [N_WORD-1:0][KEY_W-1:0] key;
  logic [N_WORD-1:0][KEY_W-1:0] key_in;
  logic [SH_W-1:0] shift;
  logic [LANES-1:0][KEY_W-1:0] lane_ent;
  logic [N_WORD-1:0] hit;
  logic [N_WORD-1:0][LANE_W-1:0] lane;
  logic [N_WORD-1:0][POS_W-1:0] pos_new;
  logic last, leave;
  always_comb begin
    shift = int'(i_ite) > MAX_SHIFT ? SH_W'(MAX_SHIFT) : SH_W'(i_ite);
    for (int w = 0; w < N_WORD; w++) key_in[w] = i_word[w][shift +: KEY_W];
    for (int l = 0; l < LANES; l++) lane_ent[l] = i_IA[IDX_W'(int'(blk) * LANES + l)];
    for (int w = 0; w < N_WORD; w++) pos_new[w] = POS_W'(int'(blk) * LANES + int'(lane[w]));
  end
  for (genvar w = 0; w < N_WORD; w++) begin : g_cmp
    aim_lane_cmp #(.KEY_W(KEY_W), .LANES(LANES), .LANE_W(LANE_W)) u_cmp (
      .key(key[w]),
      .entries(lane_ent),
      .hit(hit[w]),
      .lane(lane[w])
    );
  end
  assign last = blk == BLK_W'(N_BLK - 1);
`ifdef AIM_EARLY_EXIT_EN
  // words matched in this very block count toward the early exit
  assign leave = last || (&(o_valid | hit));
`else
  assign leave = last;
`endif
  assign o_busy = state != IDLE;
  assign o_finish = state == DONE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      blk <= '0;
      o_valid <= '0;
      o_pos <= {N_WORD{NO_POS}};
    end else if (state == IDLE) begin
      if (i_start) begin
        key <= key_in;
        o_valid <= '0;
        o_pos <= {N_WORD{NO_POS}};
        blk <= '0;
        state <= SEARCH;
      end
    end else if (state == SEARCH) begin
      // an already valid word keeps its earlier (lower) position
      for (int w = 0; w < N_WORD; w++) begin
        if (!o_valid[w] && hit[w]) begin
          o_valid[w] <= 1'b1;
          o_pos[w] <= pos_new[w];
        end
      end
      blk <= blk + 1'b1;
      state <= leave ? DONE : SEARCH;
    end else begin
      state <= IDLE;
    end
  end
endmodule
